// File: rtl/hist_sig_mag_bins.sv
// Per-line 4-bin {sig,mag} occupancy histogram over a window of accepted samples.
// Closed windows are banked for lockable register readout; saturation is reported per window.
module hist_sig_mag_bins #(
  parameter int LINES   = 4,
  parameter int CNT_W   = 16,
  parameter int WIN_W   = 16,
  parameter int WIN_LEN = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [LINES-1:0] sig,
  input  logic [LINES-1:0] mag,
  input  logic             mode,
  input  logic             start,
  input  logic             lock,
  input  logic [7:0]       rd_line,
  input  logic [1:0]       rd_bin,
  output logic [CNT_W-1:0] rd_data,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam int              LIDX_W   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIN_W-1:0] win_q;
  logic             sat_q;
  logic             sat_d;
  logic [CNT_W-1:0] acc_q  [LINES][4];
  logic [CNT_W-1:0] acc_d  [LINES][4];
  logic [CNT_W-1:0] bank_q [LINES][4];
  logic             accept_s;
  logic             close_s;

  assign busy     = (state_q == S_ACC);
  assign accept_s = busy && en;
  assign close_s  = accept_s && (win_q == WIN_LAST);

  // Next accumulator contents: one saturating increment per line on an accepted sample.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (accept_s) begin
      for (int l = 0; l < LINES; l++) begin
        if (acc_q[l][{sig[l], mag[l]}] == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          acc_d[l][{sig[l], mag[l]}] = acc_q[l][{sig[l], mag[l]}] + CNT_W'(1);
        end
      end
    end else begin
      sat_d = sat_q;
    end
  end

  // Window FSM, accumulators, bank and readout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      sat_q   <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      for (int l = 0; l < LINES; l++) begin
        for (int b = 0; b < 4; b++) begin
          acc_q[l][b]  <= '0;
          bank_q[l][b] <= '0;
        end
      end
    end else begin
      done <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!mode || start) state_q <= S_ACC;
          else                state_q <= S_IDLE;
        end
        S_ACC: begin
          if (close_s && mode) state_q <= S_IDLE;
          else                 state_q <= S_ACC;
        end
        default: state_q <= S_IDLE;
      endcase

      // The closing sample is folded into the bank; accumulation restarts from empty.
      if (close_s) begin
        bank_q <= acc_d;
        ovf    <= sat_d;
        done   <= 1'b1;
        win_q  <= '0;
        sat_q  <= 1'b0;
        for (int l = 0; l < LINES; l++) begin
          for (int b = 0; b < 4; b++) begin
            acc_q[l][b] <= '0;
          end
        end
      end else begin
        acc_q <= acc_d;
        sat_q <= sat_d;
        if (accept_s) win_q <= win_q + WIN_W'(1);
        else          win_q <= win_q;
      end

      if (lock) begin
        rd_data <= rd_data;
      end else if (32'(rd_line) < LINES) begin
        rd_data <= bank_q[rd_line[LIDX_W-1:0]][rd_bin];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hist_sig_mag_bins.sv
// Directed/randomized bench for hist_sig_mag_bins: two instances (8-bit and 3-bit counters)
// share stimulus and are compared every cycle against a count-based reference model.
module tb_hist_sig_mag_bins;

  localparam int WL = 10;

  logic       clk = 1'b0;
  logic       reset, en, mode, start, lock;
  logic [1:0] sig, mag;
  logic [7:0] rd_line;
  logic [1:0] rd_bin;
  logic [7:0] rd_data8;
  logic [2:0] rd_data3;
  logic       done8, busy8, ovf8, done3, busy3, ovf3;

  int checks = 0;
  int errors = 0;

  // Reference model: true (unbounded) counts, clipped only when compared.
  int cnt  [2][4];
  int bank [2][4];
  int m_win  = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_rd8  = 0;
  int m_rd3  = 0;
  int exp1 [2][4] = '{'{0, 0, 10, 0}, '{5, 0, 0, 5}};
  int exp4 [2][4] = '{'{3, 3, 2, 2}, '{2, 3, 3, 2}};

  hist_sig_mag_bins #(.LINES(2), .CNT_W(8), .WIN_W(8), .WIN_LEN(WL)) u_d8 (
    .clk(clk), .reset(reset), .en(en), .sig(sig), .mag(mag), .mode(mode),
    .start(start), .lock(lock), .rd_line(rd_line), .rd_bin(rd_bin),
    .rd_data(rd_data8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  hist_sig_mag_bins #(.LINES(2), .CNT_W(3), .WIN_W(8), .WIN_LEN(WL)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .sig(sig), .mag(mag), .mode(mode),
    .start(start), .lock(lock), .rd_line(rd_line), .rd_bin(rd_bin),
    .rd_data(rd_data3), .done(done3), .busy(busy3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit any_over(input int mx);
    bit r = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 4; b++)
        if (bank[l][b] > mx) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int l = 0; l < 2; l++)
        for (int b = 0; b < 4; b++) begin
          cnt[l][b]  = 0;
          bank[l][b] = 0;
        end
      m_win = 0; m_busy = 1'b0; m_done = 1'b0; m_rd8 = 0; m_rd3 = 0;
    end else begin
      if (!lock) begin
        if (rd_line < 8'd2) begin
          m_rd8 = clip(bank[rd_line][rd_bin], 255);
          m_rd3 = clip(bank[rd_line][rd_bin], 7);
        end else begin
          m_rd8 = 0;
          m_rd3 = 0;
        end
      end
      m_done = 1'b0;
      if (m_busy) begin
        if (en) begin
          for (int l = 0; l < 2; l++) cnt[l][{sig[l], mag[l]}]++;
          m_win++;
          if (m_win == WL) begin
            bank = cnt;
            for (int l = 0; l < 2; l++)
              for (int b = 0; b < 4; b++) cnt[l][b] = 0;
            m_win  = 0;
            m_done = 1'b1;
            m_busy = !mode;
          end
        end
      end else begin
        m_busy = !mode || start;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("busy8", 32'(busy8), 32'(m_busy));
    chk("busy3", 32'(busy3), 32'(m_busy));
    chk("done8", 32'(done8), 32'(m_done));
    chk("done3", 32'(done3), 32'(m_done));
    chk("ovf8",  32'(ovf8),  32'(any_over(255)));
    chk("ovf3",  32'(ovf3),  32'(any_over(7)));
    chk("rd8",   32'(rd_data8), 32'(m_rd8));
    chk("rd3",   32'(rd_data3), 32'(m_rd3));
  endtask

  task automatic set_bins(input int b0, input int b1);
    logic [1:0] v0, v1;
    v0  = 2'(b0);
    v1  = 2'(b1);
    sig = {v1[1], v0[1]};
    mag = {v1[0], v0[0]};
  endtask

  task automatic set_rand();
    sig = 2'($urandom);
    mag = 2'($urandom);
  endtask

  initial begin
    int sum;
    reset = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; lock = 1'b0;
    sig = 2'd0; mag = 2'd0; rd_line = 8'd0; rd_bin = 2'd0;
    step();
    step();
    chk("rst_rd", 32'(rd_data8), 32'd0);

    // Continuous mode, fixed patterns, two full windows
    reset = 1'b0;
    step();
    chk("t1_busy_up", 32'(busy8), 32'd1);
    en = 1'b1; rd_line = 8'd0; rd_bin = 2'd2;
    for (int i = 0; i < 20; i++) begin
      set_bins(2, (i % 2 == 0) ? 3 : 0);
      step();
      if (i == 9 || i == 19) chk("t1_done", 32'(done8), 32'd1);
      else if (i == 8)       chk("t1_no_early_done", 32'(done8), 32'd0);
    end
    en = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 4; b++) begin
        rd_line = 8'(l); rd_bin = 2'(b);
        step();
        chk("t1_bin", 32'(rd_data8), 32'(exp1[l][b]));
      end
    chk("t1_ovf8", 32'(ovf8), 32'd0);
    chk("t1_ovf3", 32'(ovf3), 32'd1);

    // en toggling: window stretches to 20 cycles, totals stay at WIN_LEN
    for (int i = 0; i < 40; i++) begin
      en = (i % 2 == 0);
      set_rand();
      step();
      if (i == 18 || i == 38) chk("t2_done", 32'(done8), 32'd1);
    end
    for (int l = 0; l < 2; l++) begin
      sum = 0;
      for (int b = 0; b < 4; b++) begin
        rd_line = 8'(l); rd_bin = 2'(b);
        step();
        sum += int'(rd_data8);
      end
      chk("t2_sum", 32'(sum), 32'(WL));
    end

    // Saturation of the 3-bit instance, then a clean window clears ovf
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_bins(1, 1);
      step();
    end
    chk("t3_done", 32'(done3), 32'd1);
    chk("t3_ovf3", 32'(ovf3), 32'd1);
    chk("t3_ovf8", 32'(ovf8), 32'd0);
    en = 1'b0; rd_line = 8'd0; rd_bin = 2'd1;
    step();
    chk("t3_sat_val", 32'(rd_data3), 32'd7);
    chk("t3_full_val", 32'(rd_data8), 32'd10);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_bins(i % 4, (i + 1) % 4);
      step();
    end
    chk("t3_done2", 32'(done3), 32'd1);
    chk("t3_ovf_clr", 32'(ovf3), 32'd0);

    // Single-shot: finish current window, idle, then two identical runs
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_rand();
      step();
    end
    chk("t4_to_idle", 32'(busy8), 32'd0);
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 3; i++) begin
        set_rand();
        step();
        chk("t4_idle", 32'(busy8), 32'd0);
      end
      start = 1'b1;
      step();
      chk("t4_launch", 32'(busy8), 32'd1);
      for (int i = 0; i < 10; i++) begin
        set_bins(i % 4, (i + 1) % 4);
        start = (i < 5);
        step();
      end
      start = 1'b0;
      chk("t4_done", 32'(done8), 32'd1);
      chk("t4_busy_low", 32'(busy8), 32'd0);
      for (int l = 0; l < 2; l++)
        for (int b = 0; b < 4; b++) begin
          rd_line = 8'(l); rd_bin = 2'(b);
          set_rand();
          step();
          chk("t4_bin", 32'(rd_data8), 32'(exp4[l][b]));
        end
    end

    // Lock freezes readout across a bank update
    lock = 1'b0; rd_line = 8'd0; rd_bin = 2'd0;
    step();
    chk("t5_pre", 32'(rd_data8), 32'd3);
    lock = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_bins(0, 0);
      step();
    end
    chk("t5_done", 32'(done8), 32'd1);
    chk("t5_locked", 32'(rd_data8), 32'd3);
    step();
    chk("t5_locked2", 32'(rd_data8), 32'd3);
    lock = 1'b0;
    step();
    chk("t5_unlock", 32'(rd_data8), 32'd10);
    rd_line = 8'd5;
    step();
    chk("t5_oob", 32'(rd_data8), 32'd0);

    // Mid-window reset, then a full fresh window
    mode = 1'b0; en = 1'b1;
    step();
    chk("t6_busy", 32'(busy8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_rand();
      step();
    end
    reset = 1'b1;
    step();
    chk("t6_rst_busy", 32'(busy8), 32'd0);
    chk("t6_rst_done", 32'(done8), 32'd0);
    chk("t6_rst_rd", 32'(rd_data8), 32'd0);
    chk("t6_rst_ovf", 32'(ovf3), 32'd0);
    reset = 1'b0; rd_line = 8'd0;
    step();
    for (int i = 0; i < 10; i++) begin
      set_bins(2, 3);
      step();
      if (i == 8) chk("t6_no_early_done", 32'(done8), 32'd0);
    end
    chk("t6_done", 32'(done8), 32'd1);
    en = 1'b0; rd_line = 8'd0; rd_bin = 2'd2;
    step();
    chk("t6_l0", 32'(rd_data8), 32'd10);
    rd_line = 8'd1; rd_bin = 2'd3;
    step();
    chk("t6_l1", 32'(rd_data8), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_sig_mag_bins.md
# hist_sig_mag_bins

Per-line 4-bin sign/magnitude histogram for the imitator DSP path. Each of LINES 2-bit ADC streams ({sig,mag}) is counted into four occupancy bins over a window of WIN_LEN accepted samples. The block runs either back-to-back (continuous) or one window per start request (single-shot). Closed windows are banked for register-side readout with a lock-freeze and a saturation flag.

## Interface
- LINES, 4: number of analysed lines, 1..256
- CNT_W, 16: bin counter and result width, 2..32
- WIN_W, 16: window counter width
- WIN_LEN, 65535: accepted samples per window, 2..2^WIN_W-1

- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- en  in  1  sample valid; sig/mag counted only when en=1 and busy=1
- sig  in  LINES  sign bit per line
- mag  in  LINES  magnitude bit per line
- mode  in  1  0 = continuous, 1 = single-shot
- start  in  1  single-shot trigger, level sampled per cycle
- lock  in  1  1 = freeze rd_data
- rd_line  in  8  line select for readout
- rd_bin  in  2  bin select, bin = {sig,mag}
- rd_data  out  CNT_W  selected banked count
- done  out  1  one-cycle pulse: bank updated
- busy  out  1  window accumulation in progress
- ovf  out  1  any bin saturated in last banked window

## Operation
- FSM states:
  - IDLE -> ACC:
    - mode=0: unconditionally.
    - mode=1: when start=1.
  - ACC -> close window on the cycle the WIN_LEN-th sample is accepted. Then:
    - mode=0: stay in ACC.
    - mode=1: go to IDLE.
  - mode is sampled only at window close and in IDLE.
  - start is ignored while in ACC.
- busy = (state==ACC).
- Accepted sample: busy=1 and en=1.
  - Window counter +1 per accepted sample.
  - Each line increments acc[line][{sig,mag}].
  - en=0 cycles count nothing and do not advance the window.
- Bin counters saturate at 2^CNT_W-1; no wrap. A per-window sticky sat flag is set on any attempted increment past max.
- Window close:
  - bank[l][b] <= the next value of acc, i.e. including the closing sample.
  - ovf <= sat, including a saturation caused by the closing sample.
  - acc, window counter and sat clear in the same edge.
  - The next accepted sample starts the new window from 1.
- Without saturation, the four bins of each line sum exactly to WIN_LEN.
- Readout:
  - If lock=0: rd_data <= bank[rd_line][rd_bin]. If lock=1: rd_data holds.
  - rd_line >= LINES reads 0.
- Reset (any time, including mid-window) clears:
  - acc, sat, window counter, bank, ovf;
  - rd_data=0, done=0, busy=0;
  - state returns to IDLE.

## Timing
- Reset values: rd_data=0, done=0, busy=0, ovf=0, all bank entries 0.
- After reset release:
  - mode=0: busy rises at the first edge.
  - mode=1: busy rises at the edge that samples start=1.
- done is registered and high for exactly the one cycle following the close edge. bank and ovf hold the new values in that same cycle.
- rd_data latency: 1 cycle from rd_line/rd_bin/lock, or from bank update.
  - With lock=0 and fixed address, new data appears on rd_data one cycle after done.
- In continuous mode there is no dead cycle between windows; a sample accepted in the cycle done is high belongs to the new window.
- Single-shot: busy falls in the cycle done is high. A start in that same cycle relaunches, with busy high the next cycle.

## Test plan
1. LINES=2, CNT_W=8, WIN_LEN=10, mode=0, en=1.
   - Stimulus: line0 constant {1,0}; line1 alternating 11/00.
   - Required: done 10 cycles after busy rises; line0 bin2=10, other bins 0; line1 bin3=5, bin0=5; ovf=0; done repeats every 10 cycles.
2. Same config, en toggling 1,0,1,0...
   - Required: done every 20 cycles; bin totals still 10.
3. CNT_W=3, WIN_LEN=10, all samples {0,1}.
   - Required: bin1=7; ovf=1 with done. Next window with mixed data and no saturation -> ovf=0.
4. mode=1, start pulse.
   - Required: busy high for 10 en cycles, one done, busy low.
   - Required: bank stable afterwards; start held during busy is ignored.
   - Required: second start gives a second identical result.
5. lock=1 asserted before done.
   - Required: rd_data keeps the old value through done.
   - Required: lock=0 -> new value after 1 cycle; rd_line=5 (>= LINES) -> 0.
6. reset pulse after 5 samples.
   - Required: rd_data=0, ovf=0, busy=0, no done.
   - Required: after release the next window counts a full 10 samples.
